snake_game_ctrl: RTL and testbench

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_tick_div.sv | 40 ++++
 rtl/snake_game_ctrl.sv | 163 ++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
// ST_PAUSE exists only when SNAKE_PAUSE_EN is defined.
package snake_pkg;

    localparam int X_W     = 6;
    localparam int Y_W     = 5;
    localparam int SCORE_W = 8;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_RESPAWN,
        ST_OVER
`ifdef SNAKE_PAUSE_EN
        , ST_PAUSE
`endif
    } state_t;

    // Opposite heading: up<->down, right<->left.
    function automatic dir_t dir_reverse(input dir_t d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Move-tick generator: score-dependent period, freezable counter, one-cycle tick.
module snake_tick_div
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 250000,
    parameter int unsigned MIN_DIV    = 62500,
    parameter int unsigned SPEED_STEP = 15625
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_freeze,
    input  logic [SCORE_W-1:0] i_score,
    output logic               o_tick
);

    logic [39:0] w_dec;
    logic [31:0] w_diff;
    logic [31:0] w_period;
    logic [31:0] r_count;

    // Wide product so the reduction can never wrap before the compare.
    assign w_dec = 40'(i_score) * 40'(SPEED_STEP);

    always_comb begin
        w_diff   = (w_dec >= 40'(TICK_DIV)) ? 32'd0 : (TICK_DIV - w_dec[31:0]);
        w_period = (w_diff > MIN_DIV) ? w_diff : MIN_DIV;
    end

    assign o_tick = !i_freeze && ((r_count + 32'd1) >= w_period);

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_count <= '0;
        end else if (!i_freeze) begin
            r_count <= o_tick ? '0 : r_count + 32'd1;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: game FSM, direction arbitration, scoring, apple respawn.
// Optional pause input and state are built when SNAKE_PAUSE_EN is defined.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 250000,
    parameter int unsigned MIN_DIV    = 62500,
    parameter int unsigned SPEED_STEP = 15625
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef SNAKE_PAUSE_EN
    input  logic               pause,
`endif
    input  logic               dir_valid,
    input  logic [1:0]         dir_in,
    input  logic [X_W-1:0]     head_x,
    input  logic [Y_W-1:0]     head_y,
    input  logic [X_W-1:0]     apple_x,
    input  logic [Y_W-1:0]     apple_y,
    input  logic               wall_hit,
    input  logic               self_hit,
    input  logic               spawn_ack,
    output logic               move_tick,
    output logic [1:0]         dir_out,
    output logic               grow,
    output logic               spawn_req,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               clear_board
);

    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    dir_t               r_dir, w_dir_nxt;
    dir_t               r_pend, w_pend_nxt;
    logic               r_move_tick;
    logic               r_grow, w_grow_nxt;
    logic               r_spawn_req, w_spawn_nxt;
    logic               r_clear, w_clear_nxt;
    logic               w_tick;
    logic               w_freeze;
    logic               w_start_game;
    logic               w_eat;

    assign w_eat        = (head_x == apple_x) && (head_y == apple_y);
    assign w_start_game = start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
`ifdef SNAKE_PAUSE_EN
    assign w_freeze = (r_state != ST_RUN) || pause;
`else
    assign w_freeze = (r_state != ST_RUN);
`endif

    snake_tick_div #(
        .TICK_DIV   (TICK_DIV),
        .MIN_DIV    (MIN_DIV),
        .SPEED_STEP (SPEED_STEP)
    ) u_tick_div (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_start_game),
        .i_freeze (w_freeze),
        .i_score  (r_score),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_dir_nxt   = r_dir;
        w_pend_nxt  = r_pend;
        w_grow_nxt  = 1'b0;
        w_clear_nxt = 1'b0;
        w_spawn_nxt = r_spawn_req;

        unique case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_start_game) begin
                    w_state_nxt = ST_RUN;
                    w_score_nxt = '0;
                    w_dir_nxt   = DIR_RIGHT;
                    w_pend_nxt  = DIR_RIGHT;
                    w_clear_nxt = 1'b1;
                end
            end
            ST_RUN: begin
`ifdef SNAKE_PAUSE_EN
                if (pause) begin
                    w_state_nxt = ST_PAUSE;
                end else
`endif
                if (w_tick) begin
                    w_state_nxt = ST_CHECK;
                    w_dir_nxt   = r_pend;
                end
            end
            ST_CHECK: begin
                if (wall_hit || self_hit) begin
                    w_state_nxt = ST_OVER;
                end else if (w_eat) begin
                    w_state_nxt = ST_RESPAWN;
                    w_grow_nxt  = 1'b1;
                    w_spawn_nxt = 1'b1;
                    w_score_nxt = (r_score == SCORE_MAX) ? r_score : r_score + 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RESPAWN: begin
                if (spawn_ack) begin
                    w_state_nxt = ST_RUN;
                    w_spawn_nxt = 1'b0;
                end
            end
`ifdef SNAKE_PAUSE_EN
            ST_PAUSE: begin
                if (pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

        // Reverse test uses the heading in force after this edge, so a request
        // landing on a tick cannot queue a U-turn against the new direction.
        if (!w_start_game && dir_valid && (dir_in != dir_reverse(w_dir_nxt))) begin
            w_pend_nxt = dir_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_score     <= '0;
            r_dir       <= DIR_RIGHT;
            r_pend      <= DIR_RIGHT;
            r_move_tick <= 1'b0;
            r_grow      <= 1'b0;
            r_spawn_req <= 1'b0;
            r_clear     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_dir       <= w_dir_nxt;
            r_pend      <= w_pend_nxt;
            r_move_tick <= w_tick;
            r_grow      <= w_grow_nxt;
            r_spawn_req <= w_spawn_nxt;
            r_clear     <= w_clear_nxt;
        end
    end

    assign move_tick   = r_move_tick;
    assign dir_out     = r_dir;
    assign grow        = r_grow;
    assign spawn_req   = r_spawn_req;
    assign score       = r_score;
    assign game_over   = (r_state == ST_OVER);
    assign clear_board = r_clear;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus random play, all checked
// cycle by cycle against a game-rule model. Covers pause when SNAKE_PAUSE_EN is set.
module tb_snake_game_ctrl;

    localparam int unsigned TD = 10;
    localparam int unsigned MD = 4;
    localparam int unsigned SS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
`ifdef SNAKE_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'd0;
    logic [5:0] head_x = 6'd11;
    logic [4:0] head_y = 5'd7;
    logic [5:0] apple_x = 6'd10;
    logic [4:0] apple_y = 5'd7;
    logic       wall_hit = 1'b0;
    logic       self_hit = 1'b0;
    logic       spawn_ack = 1'b0;
    logic       move_tick;
    logic [1:0] dir_out;
    logic       grow;
    logic       spawn_req;
    logic [7:0] score;
    logic       game_over;
    logic       clear_board;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .TICK_DIV   (TD),
        .MIN_DIV    (MD),
        .SPEED_STEP (SS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef SNAKE_PAUSE_EN
        .pause       (pause),
`endif
        .dir_valid   (dir_valid),
        .dir_in      (dir_in),
        .head_x      (head_x),
        .head_y      (head_y),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .wall_hit    (wall_hit),
        .self_hit    (self_hit),
        .spawn_ack   (spawn_ack),
        .move_tick   (move_tick),
        .dir_out     (dir_out),
        .grow        (grow),
        .spawn_req   (spawn_req),
        .score       (score),
        .game_over   (game_over),
        .clear_board (clear_board)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Game-rule model: phase of play, RUN cycles since the last move, score, headings.
    localparam int M_IDLE = 0, M_RUN = 1, M_CHECK = 2, M_RESP = 3, M_OVER = 4, M_PAUSE = 5;
    int m_mode, m_score, m_dir, m_pend, m_elapsed;
    bit m_tick, m_grow, m_spawn, m_clear;
    bit m_valid = 1'b0;

    function automatic int period_of(input int s);
        int p;
        p = int'(TD) - s * int'(SS);
        return (p > int'(MD)) ? p : int'(MD);
    endfunction

    always @(posedge clk) begin
        int p_in;
        bit fresh;
`ifdef SNAKE_PAUSE_EN
        p_in = int'(pause);
`else
        p_in = 0;
`endif
        fresh = 1'b0;
        if (!reset) begin
            m_valid = 1'b1;
            m_mode = M_IDLE; m_score = 0; m_dir = 1; m_pend = 1; m_elapsed = 0;
            m_tick = 0; m_grow = 0; m_spawn = 0; m_clear = 0;
        end else if (m_valid) begin
            m_tick = 0; m_grow = 0; m_clear = 0;
            case (m_mode)
                M_IDLE, M_OVER: if (start) begin
                    m_mode = M_RUN; m_score = 0; m_dir = 1; m_pend = 1;
                    m_elapsed = 0; m_clear = 1; fresh = 1'b1;
                end
                M_RUN: if (p_in != 0) m_mode = M_PAUSE;
                else begin
                    m_elapsed++;
                    if (m_elapsed == period_of(m_score)) begin
                        m_elapsed = 0; m_tick = 1; m_mode = M_CHECK; m_dir = m_pend;
                    end
                end
                M_CHECK: if (wall_hit || self_hit) m_mode = M_OVER;
                else if (head_x == apple_x && head_y == apple_y) begin
                    m_grow = 1; m_spawn = 1; m_mode = M_RESP;
                    if (m_score < 255) m_score++;
                end else m_mode = M_RUN;
                M_RESP: if (spawn_ack) begin m_spawn = 0; m_mode = M_RUN; end
                M_PAUSE: if (p_in != 0) m_mode = M_RUN;
                default: m_mode = M_IDLE;
            endcase
            if (!fresh && dir_valid && int'(dir_in) != (m_dir + 2) % 4) m_pend = int'(dir_in);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("move_tick",   int'(move_tick),   int'(m_tick));
            chk("grow",        int'(grow),        int'(m_grow));
            chk("spawn_req",   int'(spawn_req),   int'(m_spawn));
            chk("clear_board", int'(clear_board), int'(m_clear));
            chk("score",       int'(score),       m_score);
            chk("dir_out",     int'(dir_out),     m_dir);
            chk("game_over",   int'(game_over),   int'(m_mode == M_OVER));
        end
    end

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (move_tick !== 1'b1 && n < 1000);
        if (move_tick !== 1'b1) chk("tick_timeout", 0, 1);
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Called in CHECK: eat, ack at once, then wait for the next move tick.
    task automatic eat_one(output int n, output int g, output int s);
        head_x = apple_x; head_y = apple_y;
        @(negedge clk);
        g = int'(grow); s = int'(score);
        head_x = apple_x + 6'd1; spawn_ack = 1'b1;
        @(negedge clk);
        spawn_ack = 1'b0;
        wait_tick(n);
    endtask

    initial begin
        int n, g, s, cnt;
        int exp_per[3];
        exp_per = '{6, 4, 4};

        repeat (3) @(negedge clk);
        chk("rst_score", int'(score), 0);
        chk("rst_dir", int'(dir_out), 1);
        chk("rst_spawn", int'(spawn_req), 0);
        chk("rst_over", int'(game_over), 0);
        reset = 1'b1;

        // First game: clear pulse, direction arbitration, first tick latency.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("clear_pulse", int'(clear_board), 1);
        dir_valid = 1'b1; dir_in = 2'd3;
        @(negedge clk); chk("clear_once", int'(clear_board), 0); dir_in = 2'd0;
        @(negedge clk); dir_in = 2'd2;
        @(negedge clk); dir_valid = 1'b0;
        chk("dir_hold", int'(dir_out), 1);
        wait_tick(n);
        chk("first_tick_lat", n + 3, 10);
        chk("dir_last_wins", int'(dir_out), 2);

        // Eat with a slow ack.
        head_x = apple_x; head_y = apple_y;
        @(negedge clk);
        chk("eat_grow", int'(grow), 1);
        chk("eat_score", int'(score), 1);
        chk("eat_spawn", int'(spawn_req), 1);
        head_x = apple_x + 6'd1;
        repeat (4) @(negedge clk);
        chk("spawn_hold", int'(spawn_req), 1);
        spawn_ack = 1'b1;
        @(negedge clk); spawn_ack = 1'b0;
        chk("spawn_drop", int'(spawn_req), 0);
        wait_tick(n);
        chk("period_s1", n, 8);

        for (int i = 0; i < 3; i++) begin
            eat_one(n, g, s);
            chk("period_s", n, exp_per[i]);
        end

        // Collision beats apple.
        wall_hit = 1'b1; head_x = apple_x; head_y = apple_y;
        @(negedge clk);
        chk("over_flag", int'(game_over), 1);
        chk("over_no_grow", int'(grow), 0);
        chk("over_score", int'(score), 4);
        wall_hit = 1'b0; head_x = apple_x + 6'd1;
        repeat (3) @(negedge clk);
        chk("over_stays", int'(game_over), 1);
        start_pulse();
        chk("restart_score", int'(score), 0);
        chk("restart_over", int'(game_over), 0);
        chk("restart_clear", int'(clear_board), 1);
        dir_valid = 1'b1; dir_in = 2'd3;
        @(negedge clk); dir_valid = 1'b0;
        wait_tick(n);
        chk("reverse_ignored", int'(dir_out), 1);

        // Saturation.
        for (int i = 0; i < 256; i++) begin
            eat_one(n, g, s);
            if (i == 254) chk("sat_reach", s, 255);
            if (i == 255) begin
                chk("sat_score", s, 255);
                chk("sat_grow", g, 1);
                chk("sat_period", n, 4);
            end
        end

        // Reset in RESPAWN.
        head_x = apple_x; head_y = apple_y;
        @(negedge clk);
        chk("resp_spawn", int'(spawn_req), 1);
        reset = 1'b0; head_x = apple_x + 6'd1;
        @(negedge clk);
        chk("rst_resp_spawn", int'(spawn_req), 0);
        chk("rst_resp_score", int'(score), 0);
        reset = 1'b1; spawn_ack = 1'b1;
        @(negedge clk); spawn_ack = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (move_tick || spawn_req) cnt++;
        end
        chk("idle_quiet", cnt, 0);

`ifdef SNAKE_PAUSE_EN
        start_pulse();
        repeat (3) @(negedge clk);
        pause = 1'b1;
        @(negedge clk); pause = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (move_tick) cnt++;
        end
        chk("pause_frozen", cnt, 0);
        pause = 1'b1;
        @(negedge clk); pause = 1'b0;
        wait_tick(n);
        chk("pause_resume", int'(n <= 10), 1);
`endif

        // Random play.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 299) != 0);
            start     = ($urandom_range(0, 39) == 0);
            dir_valid = ($urandom_range(0, 3) == 0);
            dir_in    = 2'($urandom_range(0, 3));
            wall_hit  = ($urandom_range(0, 15) == 0);
            self_hit  = ($urandom_range(0, 15) == 0);
            spawn_ack = ($urandom_range(0, 3) == 0);
`ifdef SNAKE_PAUSE_EN
            pause     = ($urandom_range(0, 30) == 0);
`endif
            if ($urandom_range(0, 2) == 0) begin
                head_x = apple_x; head_y = apple_y;
            end else begin
                head_x = 6'($urandom_range(9, 11));
                head_y = 5'($urandom_range(6, 8));
            end
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
